// File: rtl/timer_peripheral_pkg.sv
// Shared definitions for the memory-mapped timer: register word offsets,
// TCON bit positions and the address-offset decoder.
package timer_peripheral_pkg;

    // Word offsets from BASE_ADDR (byte offset / 4)
    localparam logic [29:0] OFF_TH      = 30'd0;
    localparam logic [29:0] OFF_TL      = 30'd1;
    localparam logic [29:0] OFF_TCON    = 30'd2;
    localparam logic [29:0] OFF_SYSTICK = 30'd5;

    // TCON bit indices
    localparam int unsigned TCON_EN = 0;  // count enable
    localparam int unsigned TCON_IE = 1;  // interrupt enable
    localparam int unsigned TCON_IS = 2;  // interrupt status (sticky)

    typedef enum logic [2:0] {
        RegNone,
        RegTh,
        RegTl,
        RegTcon,
        RegSystick
    } reg_sel_e;

    // Map a word offset to a register; offsets 3 and 4 belong to other
    // peripherals and must not be claimed.
    function automatic reg_sel_e decode_offset(input logic [29:0] off);
        case (off)
            OFF_TH:      return RegTh;
            OFF_TL:      return RegTl;
            OFF_TCON:    return RegTcon;
            OFF_SYSTICK: return RegSystick;
            default:     return RegNone;
        endcase
    endfunction

endpackage

// File: rtl/timer_peripheral_prescaler.sv
// Clock prescaler: counts 0..PRESCALE-1 while enabled and flags the last
// count with a single-cycle tick. Holds while disabled; clear wins over
// counting.
module timer_peripheral_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Tick decode and next count value
    always_comb begin
        tick    = enable && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? 16'd0 : count_q + 16'd1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer with reload, sticky overflow interrupt and a free-running
// system tick. Reads are combinational from current register state, so a
// simultaneous read and write returns the pre-write value.
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        IRQ
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [31:0] systick_q;

    logic [29:0] word_off;
    reg_sel_e    sel;
    logic        wr_en;
    logic        tl_wr;
    logic        tick;
    logic        overflow;
    logic        unused_addr;

    assign unused_addr = ^address[1:0];

    // Address decode; an address below BASE wraps to a large offset and misses
    always_comb begin
        word_off = address[31:2] - BASE_ADDR[31:2];
        sel      = decode_offset(word_off);
    end

    assign hit   = (sel != RegNone);
    assign wr_en = MemWrite && hit;
    assign tl_wr = wr_en && (sel == RegTl);

    timer_peripheral_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(tcon_q[TCON_EN]),
        .clear (tl_wr),
        .tick  (tick)
    );

    // Read mux: zero unless a read strobe hits one of our registers
    always_comb begin
        read_data = '0;
        if (MemRead) begin
            case (sel)
                RegTh:      read_data = th_q;
                RegTl:      read_data = tl_q;
                RegTcon:    read_data = {29'd0, tcon_q};
                RegSystick: read_data = systick_q;
                default:    read_data = '0;
            endcase
        end
    end

    // Next-state for TH, TL and TCON with the simultaneous-event priorities
    always_comb begin
        th_d     = th_q;
        tl_d     = tl_q;
        tcon_d   = tcon_q;
        overflow = 1'b0;

        if (wr_en && (sel == RegTh)) begin
            th_d = write_data;
        end

        // A software TL write suppresses both increment and reload
        if (tl_wr) begin
            tl_d = write_data;
        end else if (tick) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d     = th_q;  // old TH even if TH is written this cycle
                overflow = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr_en && (sel == RegTcon)) begin
            tcon_d = write_data[2:0];
        end
        // Hardware set beats a software clear so no interrupt is lost
        if (overflow && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end
    end

    // Register state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_q + 32'd1;
        end
    end

    // Level interrupt purely from registered bits, so it cannot glitch
    assign IRQ = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
- Memory-mapped timer and system-tick block that sits directly downstream of the CPU's MEM stage on the pseudo bus.
- Decodes the bus address, MemRead/MemWrite and write_data driven from the EX/MEM register.
- Returns read data combinationally into the MEM-stage mux.
- Drives the IRQ line that the CPU's Control unit samples in ID to raise an interrupt to 0x80000004.

Parameters:
BASE_ADDR, 32'h40000000, byte address of TH; TL = BASE+4, TCON = BASE+8, SYSTICK = BASE+20
PRESCALE, 1, clk cycles per TL increment (legal 1..65535)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MemRead  input  1  bus read strobe (EX/MEM stage)
MemWrite  input  1  bus write strobe (EX/MEM stage)
address  input  32  byte address; bits [1:0] ignored
write_data  input  32  store data
read_data  output  32  combinational read data; 0 when no register hit or MemRead=0
hit  output  1  address decodes to one of this block's four registers
IRQ  output  1  interrupt request, level, = TCON[1] & TCON[2]

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on rising clk.
- Reset values: TH=0, TL=0, TCON=0, SYSTICK=0, prescale counter=0, so IRQ=0 and read_data=0.
- Registers:
  - TH (reload value, R/W).
  - TL (counter, R/W).
  - TCON[2:0] (R/W): bit0 = count enable, bit1 = interrupt enable, bit2 = interrupt status. Bits [31:3] read 0; writes to them are ignored.
  - SYSTICK (read-only).
- Decode: hit when address[31:2] matches one of the four word addresses. Any other offset in BASE..BASE+20 (LED/SSD region) is not hit.
- Prescaler:
  - Counts 0..PRESCALE-1 while TCON[0]=1, then wraps. tick is asserted on the cycle where the count is PRESCALE-1.
  - Held at its current value while TCON[0]=0.
  - Cleared by any write to TL.
  - PRESCALE=1 gives a tick every cycle.
- Counting on tick: if TL==32'hFFFFFFFF, TL<=TH and overflow is asserted for that cycle. Otherwise TL<=TL+1. Arithmetic is 32-bit modulo.
- Overflow: if TCON[1]=1, TCON[2]<=1 (sticky). If TCON[1]=0, the status bit is not set.
- SYSTICK: increments every cycle unconditionally, wraps at 2^32. Writes are ignored.
- Write latency: a register write is visible on read the cycle after the MemWrite edge.
- Read latency: 0 cycles, combinational from current register state.
- Priorities on simultaneous events in one cycle:
  - TL write vs. tick: the write wins; no increment or reload that cycle.
  - TH write vs. overflow reload: the reload uses the OLD TH.
  - TCON write clearing bit2 vs. hardware overflow set: the set wins, so no interrupt is lost. Bits 1:0 still take the written value.
  - TCON write that sets bit0=0 while a tick is pending: the tick that cycle is still applied (the enable is registered).
- IRQ:
  - Is the AND of the registered bits. It deasserts the cycle after software clears bit2 or bit1.
  - Must not glitch on unrelated bus writes.
- MemRead and MemWrite asserted together: the write is performed, and read_data shows the pre-write value.
- Reset mid-count: all state returns to reset values on the next edge, including any pending IRQ.

Decomposition:
- Shared package: register offset localparams (OFF_TH=0, OFF_TL=1, OFF_TCON=2, OFF_SYSTICK=5 as word indices), and TCON bit-index constants TCON_EN, TCON_IE, TCON_IS.
- One natural sub-module: timer_prescaler (counter plus tick output, with clear/enable inputs), reused by a later watchdog.
- Decode, register file and read mux stay in timer_peripheral.

Test Plan:
- Reset, then read each register -> read_data=0 for TH/TL/TCON, IRQ=0. A read of BASE+12 -> hit=0, read_data=0.
- Write TH=32'hFFFFFFF0, TL=32'hFFFFFFFC, TCON=3, PRESCALE=1:
  - TL reads FFFFFFFD..FFFFFFFF on successive cycles, then FFFFFFF0.
  - TCON reads 7 the cycle after the overflow edge, and IRQ=1.
- With IRQ=1, write TCON=3 -> IRQ=0 next cycle. Repeat with the write landing exactly on an overflow cycle -> TCON stays 7 and IRQ stays 1.
- TCON=1 (IE=0) through overflow -> TL reloads and TCON stays 1, IRQ never asserts. Write TL=5 on the same cycle as a tick -> TL reads 5, then 6.
- PRESCALE=4, TL=0, TCON=1 -> TL increments once per 4 clks (0,0,0,0,1,...). Clearing TCON[0] freezes both TL and the prescaler.
- SYSTICK reads N then N+k after k cycles. Writing 32'h1234 to SYSTICK has no effect. Assert reset for 1 cycle mid-count -> all registers are 0 and IRQ=0 on the next read.
